// File: rtl/var_latency_responder.sv
// Variable-latency read responder: holds one request E cycles, returns data+OFFSET.
// Define VAR_LATENCY_RESPONDER_CLAMP_EN to clamp latency into [MIN_LAT, MAX_LAT].
module var_latency_responder #(
    parameter int DW      = 32,
    parameter int LW      = 8,
    parameter int MIN_LAT = 10,
    parameter int MAX_LAT = 20,
    parameter int OFFSET  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_data,
    input  logic [LW-1:0] req_lat,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          lat_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [LW-1:0] MinL = LW'(MIN_LAT);
    localparam logic [LW-1:0] MaxL = LW'(MAX_LAT);

    state_e        state_q;
    logic [LW-1:0] cnt_q;
    logic [DW-1:0] rsp_data_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic          busy_q;
    logic          lat_err_q;

    logic [LW-1:0] eff_lat_d;
    logic [DW-1:0] rsp_data_d;
    logic          lat_bad_d;

    always_comb begin
        lat_bad_d  = (req_lat < MinL) || (req_lat > MaxL);
        rsp_data_d = req_data + DW'(OFFSET);
`ifdef VAR_LATENCY_RESPONDER_CLAMP_EN
        if (req_lat < MinL)
            eff_lat_d = MinL;
        else if (req_lat > MaxL)
            eff_lat_d = MaxL;
        else
            eff_lat_d = req_lat;
`else
        eff_lat_d = (req_lat == '0) ? LW'(1) : req_lat;
`endif
    end

    // rsp_valid is set one edge early (cnt==2) so it is seen at edge k+E
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            lat_err_q   <= 1'b0;
        end else begin
            lat_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        rsp_data_q  <= rsp_data_d;
                        lat_err_q   <= lat_bad_d;
                        cnt_q       <= eff_lat_d;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (eff_lat_d == LW'(1)) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - LW'(1);
                    if (cnt_q == LW'(2)) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign lat_err   = lat_err_q;

endmodule

// File: tb/tb_var_latency_responder.sv
// Directed bench for var_latency_responder: latency, data, handshake, reset.
// Honours VAR_LATENCY_RESPONDER_CLAMP_EN for expected latencies.
module tb_var_latency_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic [7:0]  req_lat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic        lat_err;

    int total;
    int passed;
    int fails;

`ifdef VAR_LATENCY_RESPONDER_CLAMP_EN
    localparam int L25 = 20;
    localparam int L0  = 10;
`else
    localparam int L25 = 25;
    localparam int L0  = 1;
`endif

    var_latency_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_lat   (req_lat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .lat_err   (lat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with req_ready high; returns at a negedge.
    task automatic do_req(input logic [31:0] d, input logic [7:0] l,
                          input int exp_lat, input logic exp_err,
                          input int hold);
        logic [31:0] exp_d;
        int n;
        exp_d = d + 32'd10;
        req_valid = 1'b1;
        req_data  = d;
        req_lat   = l;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = ~d;
        req_lat   = 8'd0;
        chk("lat_err_pulse", {31'd0, lat_err}, {31'd0, exp_err});
        chk("busy_held", {31'd0, busy}, 32'd1);
        chk("ready_low", {31'd0, req_ready}, 32'd0);
        n = 1;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_lat);
        chk("rsp_data", rsp_data, exp_d);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_data", rsp_data, exp_d);
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_valid", {31'd0, rsp_valid}, 32'd0);
        chk("done_ready", {31'd0, req_ready}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_err", {31'd0, lat_err}, 32'd0);
    endtask

    initial begin
        bit seen;
        total     = 0;
        passed    = 0;
        fails     = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data  = '0;
        req_lat   = '0;
        rsp_ready = 1'b0;
        #12;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, lat_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(32'd56, 8'd15, 15, 1'b0, 0);
        do_req(32'h1234, 8'd10, 10, 1'b0, 0);
        do_req(32'h5678, 8'd20, 20, 1'b0, 0);
        do_req(32'hFFFF_FFFA, 8'd25, L25, 1'b1, 0);
        do_req(32'h0000_00AB, 8'd0, L0, 1'b1, 0);
        do_req(32'hCAFE_0000, 8'd12, 12, 1'b0, 7);

        // Reset while WAIT has 5 cycles left
        req_valid = 1'b1;
        req_data  = 32'h0BAD_0000;
        req_lat   = 8'd15;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_data", rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        chk("no_stale_rsp", {31'd0, seen}, 32'd0);
        do_req(32'h0000_0001, 8'd11, 11, 1'b0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
